banked_sync_ram: RTL
====================

Name: banked_sync_ram

Overview:
- Parametrised successor to the 8-bit x 32 composed RAM.
- Word storage is split into 2^BANK_BITS banks, selected by the address MSBs.
- Adds per-byte write enables, a 1-cycle registered read with a valid strobe, and a hardware clear sequencer with a busy flag.
- Sits on the datapath memory interface; the CPU data-memory wrapper is the consumer.

Parameters:
- DATA_W, 16, word width in bits; must be a multiple of 8.
- ADDR_W, 5, word address width; DEPTH = 2^ADDR_W.
- BANK_BITS, 1, number of address MSBs used as bank select; NUM_BANKS = 2^BANK_BITS, BANK_DEPTH = DEPTH/NUM_BANKS.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- cs  input  1  chip select; wrt and rd are ignored when low.
- wrt  input  1  write request.
- rd  input  1  read request.
- addr  input  ADDR_W  word address; bank = addr[ADDR_W-1 -: BANK_BITS], row = remaining low bits.
- wdata  input  DATA_W  write data.
- be  input  DATA_W/8  byte-lane write enables; be[i] gates wdata[8i+7:8i].
- clr  input  1  one-cycle pulse that starts a full-array clear.
- rdata  output  DATA_W  registered read data.
- rvalid  output  1  one-cycle strobe; rdata is valid in the same cycle.
- busy  output  1  high while the clear sequence runs; requests are ignored while high.

Behaviour:
- Reset values:
  - rdata=0, rvalid=0, busy=1.
  - FSM state=CLEAR, row counter=0.
  - Array contents are not touched by rst. The clear sequence zeroes them after rst deasserts.
- FSM states:
  - IDLE
    - cs&wrt: write the addressed bank row; only lanes with be[i]=1 are updated.
    - cs&rd&~wrt: read; rdata=content next edge, rvalid=1 for exactly that cycle.
    - cs&wrt&rd: write only. No read is performed and rvalid=0 (write priority).
    - clr=1: go to CLEAR at the next edge with counter=0 and busy=1. If wrt, rd or clr are asserted together, clr wins and the request is dropped.
  - CLEAR
    - Each cycle, row[counter] of every bank is written to 0 in parallel; counter increments.
    - When counter==BANK_DEPTH-1, the write still occurs, then state goes to IDLE and busy goes to 0 on the same edge.
    - Total duration is BANK_DEPTH cycles.
    - wrt, rd and clr are ignored; rvalid stays 0.
- Bank enable: only the addressed bank sees a write or read enable. The output mux uses the bank select registered alongside the read, not the live addr.
- rdata holds its last value when no read occurs (never Z). rvalid is 0 in any cycle with no completed read.
- Read latency is 1 cycle. Back-to-back reads give rvalid on consecutive cycles.
- Read after write to the same address on the next cycle returns the new data. There is no same-cycle bypass, because rd and wrt cannot both be serviced.
- Counter wraps exactly at BANK_DEPTH-1 → IDLE and never exceeds it.
- rst asserted mid-CLEAR or mid-read: immediately forces reset values. The sequence restarts from row 0 after deassert. A partially written byte lane is not guaranteed.
- cs=0: no state change to the array, rvalid=0, rdata holds; the clear sequence still runs if active.

Test Plan:
- Reset/clear: pulse rst, then deassert → busy=1 for exactly 16 cycles (defaults), then 0. A read of 0x1B then returns rdata=0x0000 with rvalid=1 one cycle later.
- Bank/byte enables:
  - Write 0x1B=0x2468 be=11, then 0x0A=0x3636 be=11.
  - Write 0x1B=0xAB00 be=10.
  - Reading 0x1B → 0xAB68; reading 0x0A → 0x3636. Confirms bank independence and lane masking.
- Priority: cs=1, wrt=1, rd=1, addr=0x05, wdata=0x1111 → rvalid stays 0. A read next cycle returns 0x1111.
- Chip select / hold: after a read returning 0xAB68, drive cs=0, rd=1, addr=0x0A → rvalid=0 and rdata stays 0xAB68. A write with cs=0 does not alter memory.
- Clear while busy:
  - Fill 0x00..0x1F with nonzero data, then pulse clr.
  - During the 16-cycle busy window, issue wrt 0x03=0xFFFF and a read → both are ignored.
  - Afterwards every address reads 0x0000.
- Reset mid-clear: assert rst 5 cycles into CLEAR → busy stays 1. After deassert, busy lasts a full 16 cycles and all addresses read 0.

Source files
------------

// File: rtl/banked_sync_ram.sv
// Banked word RAM with per-byte write enables, 1-cycle registered read with
// valid strobe, and a hardware clear sequencer that zeroes every bank row by row.
`timescale 1ns/1ps
module banked_sync_ram #(
   parameter int DATA_W    = 16,
   parameter int ADDR_W    = 5,
   parameter int BANK_BITS = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cs,
   input  logic                wrt,
   input  logic                rd,
   input  logic [ADDR_W-1:0]   addr,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [DATA_W/8-1:0] be,
   input  logic                clr,
   output logic [DATA_W-1:0]   rdata,
   output logic                rvalid,
   output logic                busy
);

   localparam int NUM_BANKS  = 1 << BANK_BITS;
   localparam int ROW_W      = ADDR_W - BANK_BITS;
   localparam int BANK_DEPTH = 1 << ROW_W;
   localparam int LANES      = DATA_W / 8;
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(BANK_DEPTH - 1);

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t               state_q, state_d;
   logic [ROW_W-1:0]     cnt_q, cnt_d;
   logic                 rvalid_q, rvalid_d;
   logic [BANK_BITS-1:0] rd_bank_q, rd_bank_d;
   logic [DATA_W-1:0]    dout_q [NUM_BANKS];
   logic [DATA_W-1:0]    dout_d [NUM_BANKS];
   logic [DATA_W-1:0]    mem    [NUM_BANKS][BANK_DEPTH];

   logic [BANK_BITS-1:0] bank_sel;
   logic [ROW_W-1:0]     row_sel;
   logic                 req_ok, wr_en, rd_en, clr_wr;

   assign bank_sel = addr[ADDR_W-1 -: BANK_BITS];
   assign row_sel  = addr[ROW_W-1:0];

   // clr outranks any request issued in the same cycle; writes outrank reads
   always_comb begin
      req_ok = (state_q == IDLE) && cs && !clr;
      wr_en  = req_ok && wrt;
      rd_en  = req_ok && rd && !wrt;
      clr_wr = (state_q == CLEAR) && !rst;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (clr) begin
               state_d = CLEAR;
               cnt_d   = '0;
            end
         end
         CLEAR: begin
            if (cnt_q == LAST_ROW) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = CLEAR;
            cnt_d   = '0;
         end
      endcase
   end

   // Each bank keeps its own output register; the mux select is captured with the read
   always_comb begin
      rvalid_d  = rd_en;
      rd_bank_d = rd_en ? bank_sel : rd_bank_q;
      dout_d    = dout_q;
      for (int b = 0; b < NUM_BANKS; b++) begin
         if (rd_en && (bank_sel == BANK_BITS'(b))) begin
            dout_d[b] = mem[b][row_sel];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= CLEAR;
         cnt_q     <= '0;
         rvalid_q  <= 1'b0;
         rd_bank_q <= '0;
         for (int b = 0; b < NUM_BANKS; b++) begin
            dout_q[b] <= '0;
         end
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rvalid_q  <= rvalid_d;
         rd_bank_q <= rd_bank_d;
         dout_q    <= dout_d;
      end
   end

   // Storage is never reset; the clear sequencer zeroes one row of every bank per cycle
   always_ff @(posedge clk) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
         if (clr_wr) begin
            mem[b][cnt_q] <= '0;
         end else if (wr_en && (bank_sel == BANK_BITS'(b))) begin
            for (int l = 0; l < LANES; l++) begin
               if (be[l]) begin
                  mem[b][row_sel][8*l +: 8] <= wdata[8*l +: 8];
               end
            end
         end
      end
   end

   assign rdata  = dout_q[rd_bank_q];
   assign rvalid = rvalid_q;
   assign busy   = (state_q == CLEAR);

endmodule
